// File: rtl/param_cam.sv
// Parameterised content-addressable memory with indexed read/write/invalidate and
// lowest-index search. Define CAM_MULTI_HIT_EN to add the multi_hit_o output.
module param_cam #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  read_i,
    input  logic [ADDR_WIDTH-1:0] read_index_i,
    input  logic                  write_i,
    input  logic [ADDR_WIDTH-1:0] write_index_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic                  inval_i,
    input  logic [ADDR_WIDTH-1:0] inval_index_i,
    input  logic                  search_i,
    input  logic [DATA_WIDTH-1:0] search_data_i,
    output logic                  read_valid_o,
    output logic [DATA_WIDTH-1:0] read_value_o,
    output logic                  search_valid_o,
    output logic [ADDR_WIDTH-1:0] search_index_o,
    output logic [ADDR_WIDTH:0]   count_o
`ifdef CAM_MULTI_HIT_EN
    ,
    output logic                  multi_hit_o
`endif
);

    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DEPTH-1:0]      valid_q;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    logic                  write_ok;
    logic                  inval_ok;
    logic                  read_ok;
    logic                  write_new;
    logic                  inval_hit;
    logic                  read_hit;
    logic                  search_hit;
    logic [ADDR_WIDTH-1:0] search_idx;
`ifdef CAM_MULTI_HIT_EN
    logic                  search_multi;
`endif

    // Indices at or beyond DEPTH address no entry and are treated as no-ops.
    assign write_ok = write_i && ({1'b0, write_index_i} < DEPTH_LIM);
    assign inval_ok = inval_i && ({1'b0, inval_index_i} < DEPTH_LIM);
    assign read_ok  = {1'b0, read_index_i} < DEPTH_LIM;

    // A same-index write cancels the invalidate, so only a real valid->invalid
    // transition decrements the count.
    assign write_new = write_ok && !valid_q[write_index_i];
    assign inval_hit = inval_ok && valid_q[inval_index_i] &&
                       !(write_ok && (write_index_i == inval_index_i));
    assign read_hit  = read_i && read_ok && valid_q[read_index_i];

    // Scan from the top down so the last match recorded is the lowest index.
    always_comb begin
        search_hit = 1'b0;
        search_idx = '0;
`ifdef CAM_MULTI_HIT_EN
        search_multi = 1'b0;
`endif
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (data_q[i] == search_data_i)) begin
`ifdef CAM_MULTI_HIT_EN
                if (search_hit) search_multi = 1'b1;
`endif
                search_hit = 1'b1;
                search_idx = ADDR_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
            count_o <= '0;
        end else begin
            if (inval_ok) valid_q[inval_index_i] <= 1'b0;
            // Write comes after invalidate so it wins on a shared index.
            if (write_ok) begin
                valid_q[write_index_i] <= 1'b1;
                data_q[write_index_i]  <= write_data_i;
            end
            count_o <= count_o + (ADDR_WIDTH + 1)'(write_new) - (ADDR_WIDTH + 1)'(inval_hit);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            read_valid_o   <= 1'b0;
            read_value_o   <= '0;
            search_valid_o <= 1'b0;
            search_index_o <= '0;
`ifdef CAM_MULTI_HIT_EN
            multi_hit_o    <= 1'b0;
`endif
        end else begin
            read_valid_o   <= read_hit;
            read_value_o   <= read_hit ? data_q[read_index_i] : '0;
            search_valid_o <= search_i && search_hit;
            search_index_o <= (search_i && search_hit) ? search_idx : '0;
`ifdef CAM_MULTI_HIT_EN
            multi_hit_o    <= search_i && search_multi;
`endif
        end
    end

endmodule

// File: tb/tb_param_cam.sv
// Scoreboard bench for param_cam: a reference model predicts each cycle's
// registered outputs, which are queued and compared one cycle later.
module tb_param_cam;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 24;

    typedef struct {
        logic          rv;
        logic [DW-1:0] rval;
        logic          sv;
        logic [AW-1:0] sidx;
        logic          mh;
        logic [AW:0]   cnt;
    } exp_t;

    logic          clk_i;
    logic          rst_i;
    logic          read_i;
    logic [AW-1:0] read_index_i;
    logic          write_i;
    logic [AW-1:0] write_index_i;
    logic [DW-1:0] write_data_i;
    logic          inval_i;
    logic [AW-1:0] inval_index_i;
    logic          search_i;
    logic [DW-1:0] search_data_i;
    logic          read_valid_o;
    logic [DW-1:0] read_value_o;
    logic          search_valid_o;
    logic [AW-1:0] search_index_o;
    logic [AW:0]   count_o;
`ifdef CAM_MULTI_HIT_EN
    logic          multi_hit_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic          m_valid [DEPTH];
    logic [DW-1:0] m_data  [DEPTH];
    exp_t          sb [$];

    param_cam #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .read_i         (read_i),
        .read_index_i   (read_index_i),
        .write_i        (write_i),
        .write_index_i  (write_index_i),
        .write_data_i   (write_data_i),
        .inval_i        (inval_i),
        .inval_index_i  (inval_index_i),
        .search_i       (search_i),
        .search_data_i  (search_data_i),
        .read_valid_o   (read_valid_o),
        .read_value_o   (read_value_o),
        .search_valid_o (search_valid_o),
        .search_index_o (search_index_o),
        .count_o        (count_o)
`ifdef CAM_MULTI_HIT_EN
        ,
        .multi_hit_o    (multi_hit_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
        end
        sb.delete();
    endtask

    // Drive one cycle of requests, predict the result from the pre-edge model,
    // advance the model, then compare the DUT against the oldest prediction.
    task automatic applyStimulus(input logic rd, input int ridx,
                                 input logic wr, input int widx, input logic [DW-1:0] wdata,
                                 input logic inv, input int iidx,
                                 input logic sr, input logic [DW-1:0] sdata);
        exp_t e;
        exp_t got;
        int   hits;
        int   pop;
        read_i        = rd;
        read_index_i  = AW'(ridx);
        write_i       = wr;
        write_index_i = AW'(widx);
        write_data_i  = wdata;
        inval_i       = inv;
        inval_index_i = AW'(iidx);
        search_i      = sr;
        search_data_i = sdata;

        e.rv   = rd && (ridx < DEPTH) && m_valid[ridx % DEPTH];
        e.rval = e.rv ? m_data[ridx % DEPTH] : '0;
        hits   = 0;
        e.sidx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sr && m_valid[i] && m_data[i] == sdata) begin
                if (hits == 0) e.sidx = AW'(i);
                hits++;
            end
        end
        e.sv = (hits > 0);
        e.mh = (hits > 1);

        if (inv && iidx < DEPTH) m_valid[iidx] = 1'b0;
        if (wr && widx < DEPTH) begin
            m_valid[widx] = 1'b1;
            m_data[widx]  = wdata;
        end
        pop = 0;
        for (int i = 0; i < DEPTH; i++) pop += int'(m_valid[i]);
        e.cnt = (AW + 1)'(pop);
        sb.push_back(e);

        @(posedge clk_i);
        #1;
        got = sb.pop_front();
        checkOutput("read_valid", 64'(read_valid_o), 64'(got.rv));
        checkOutput("read_value", 64'(read_value_o), 64'(got.rval));
        checkOutput("search_valid", 64'(search_valid_o), 64'(got.sv));
        checkOutput("search_index", 64'(search_index_o), 64'(got.sidx));
        checkOutput("count", 64'(count_o), 64'(got.cnt));
`ifdef CAM_MULTI_HIT_EN
        checkOutput("multi_hit", 64'(multi_hit_o), 64'(got.mh));
`endif
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, '0, 0, 0, 0, '0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_read_valid"}, 64'(read_valid_o), 64'd0);
        checkOutput({tag, "_read_value"}, 64'(read_value_o), 64'd0);
        checkOutput({tag, "_search_valid"}, 64'(search_valid_o), 64'd0);
        checkOutput({tag, "_search_index"}, 64'(search_index_o), 64'd0);
        checkOutput({tag, "_count"}, 64'(count_o), 64'd0);
`ifdef CAM_MULTI_HIT_EN
        checkOutput({tag, "_multi_hit"}, 64'(multi_hit_o), 64'd0);
`endif
    endtask

    initial begin
        logic [DW-1:0] pool [4];
        pool[0] = 32'h0000_00A5;
        pool[1] = 32'h0000_0011;
        pool[2] = 32'hDEAD_BEEF;
        pool[3] = 32'h0000_0055;

        rst_i = 1'b0;
        read_i = 0; read_index_i = '0; write_i = 0; write_index_i = '0; write_data_i = '0;
        inval_i = 0; inval_index_i = '0; search_i = 0; search_data_i = '0;
        modelReset();
        #12;
        checkAllZero("reset");
        rst_i = 1'b1;

        $display("[TB] single write then search");
        applyStimulus(0, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0, '0);
        applyStimulus(0, 0, 0, 0, '0, 0, 0, 1, 32'hDEADBEEF);

        $display("[TB] duplicate entries resolve to lowest index");
        applyStimulus(0, 0, 1, 7, 32'hA5, 0, 0, 0, '0);
        applyStimulus(0, 0, 1, 2, 32'hA5, 0, 0, 0, '0);
        applyStimulus(0, 0, 0, 0, '0, 0, 0, 1, 32'hA5);

        $display("[TB] invalidate then search misses");
        applyStimulus(0, 0, 0, 0, '0, 1, 3, 0, '0);
        applyStimulus(1, 3, 0, 0, '0, 0, 0, 1, 32'hDEADBEEF);
        idle();

        $display("[TB] read during same-cycle write sees old data");
        applyStimulus(0, 0, 1, 4, 32'h11, 0, 0, 0, '0);
        applyStimulus(1, 4, 1, 4, 32'h55, 0, 0, 1, 32'h11);
        applyStimulus(1, 4, 0, 0, '0, 0, 0, 1, 32'h55);

        $display("[TB] write beats invalidate on a shared index");
        applyStimulus(0, 0, 1, 5, 32'h77, 1, 5, 0, '0);
        applyStimulus(1, 5, 1, 6, 32'h88, 1, 5, 0, '0);
        applyStimulus(0, 0, 0, 0, '0, 1, 9, 0, '0);

        $display("[TB] indices beyond DEPTH are ignored");
        applyStimulus(1, DEPTH, 1, DEPTH, 32'hA5, 0, 0, 0, '0);
        applyStimulus(1, 31, 0, 0, '0, 1, 30, 1, 32'hA5);

        $display("[TB] random traffic");
        for (int n = 0; n < 200; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                          pool[$urandom_range(0, 3)],
                          1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)]);
        end

        $display("[TB] fill every entry");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 0, 1, i, DW'(32'h1000 + i), 0, 0, 0, '0);
        end
        applyStimulus(1, DEPTH - 1, 0, 0, '0, 0, 0, 1, DW'(32'h1000 + DEPTH - 1));
        applyStimulus(0, 0, 0, 0, '0, 0, 0, 1, DW'(32'h1000 + 5));

        $display("[TB] reset asserted mid-search");
        search_i      = 1'b1;
        search_data_i = DW'(32'h1000 + 6);
        read_i        = 1'b1;
        read_index_i  = AW'(6);
        #2;
        rst_i = 1'b0;
        #1;
        checkAllZero("midreset");
        modelReset();
        @(negedge clk_i);
        checkAllZero("heldreset");
        rst_i = 1'b1;
        applyStimulus(1, 6, 0, 0, '0, 0, 0, 1, DW'(32'h1000 + 6));
        applyStimulus(0, 0, 1, 0, 32'h42, 0, 0, 1, DW'(32'h1000 + 6));
        applyStimulus(1, 0, 0, 0, '0, 0, 0, 1, 32'h42);
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/param_cam.md
PARAM_CAM -- requirements
Module: param_cam

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning bits per entry.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning index width.
REQ-003 SHALL have parameter DEPTH, default 1<<ADDR_WIDTH, meaning entry count; legal range 2..(1<<ADDR_WIDTH).
REQ-004 SHALL have port clk_i  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i  input  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port read_i  input  1  meaning read request.
REQ-007 SHALL have port read_index_i  input  ADDR_WIDTH  meaning read entry.
REQ-008 SHALL have port write_i  input  1  meaning write request.
REQ-009 SHALL have port write_index_i  input  ADDR_WIDTH  meaning write entry.
REQ-010 SHALL have port write_data_i  input  DATA_WIDTH  meaning write value.
REQ-011 SHALL have port inval_i  input  1  meaning invalidate request.
REQ-012 SHALL have port inval_index_i  input  ADDR_WIDTH  meaning entry to invalidate.
REQ-013 SHALL have port search_i  input  1  meaning search request.
REQ-014 SHALL have port search_data_i  input  DATA_WIDTH  meaning search key.
REQ-015 SHALL have port read_valid_o  output  1  meaning read_value_o holds a valid entry.
REQ-016 SHALL have port read_value_o  output  DATA_WIDTH  meaning read result.
REQ-017 SHALL have port search_valid_o  output  1  meaning the search hit.
REQ-018 SHALL have port search_index_o  output  ADDR_WIDTH  meaning lowest matching index.
REQ-019 SHALL have port count_o  output  ADDR_WIDTH+1  meaning number of valid entries.

Function
REQ-020 SHALL store DEPTH entries, each a DATA_WIDTH data word plus a valid bit.
REQ-021 SHALL, on write_i, store write_data_i at write_index_i and set its valid bit at the next edge.
REQ-022 SHALL, on inval_i, clear the valid bit of inval_index_i at the next edge; data is kept.
REQ-023 SHALL register read results with one-cycle latency: read_valid_o = entry valid, read_value_o = entry data; both 0 when read_i was low or the entry was invalid.
REQ-024 SHALL register search results with one-cycle latency: a hit requires valid bit set and data equal to search_data_i over all DATA_WIDTH bits.
REQ-025 SHALL resolve multiple hits by reporting the lowest index; search_index_o SHALL be 0 on a miss.
REQ-026 SHALL evaluate reads and searches against pre-edge contents when a write or invalidate lands in the same cycle (no bypass).
REQ-027 SHALL give write priority over invalidate when both target the same index in one cycle; the entry ends valid.
REQ-028 SHALL keep count_o equal to the popcount of valid bits: +1 on write to an invalid entry, -1 on invalidate of a valid entry, net 0 for rewrite of a valid entry or invalidate of an invalid one, and both adjustments applied in the same cycle.
REQ-029 SHALL ignore indices >= DEPTH for write and invalidate; such reads return read_valid_o=0.
REQ-030 SHALL hold read and search outputs for one cycle only; they return to 0 the cycle after a request-free cycle.

Reset
REQ-031 SHALL, while rst_i is low, immediately clear all valid bits, data words, count_o, read_valid_o, read_value_o, search_valid_o and search_index_o to 0.
REQ-032 SHALL discard any request in flight when reset asserts mid-operation; the first request is accepted on the first rising edge with rst_i high.

Configuration
REQ-033 SHALL, with CAM_MULTI_HIT_EN defined, add output multi_hit_o (1 bit, registered with search results, reset 0) asserted when two or more valid entries match; without the macro the port and its logic SHALL be absent.

Verification
REQ-034 SHALL cover: reset, write 0xDEADBEEF at 3, search 0xDEADBEEF -> next cycle search_valid_o=1, search_index_o=3, count_o=1.
REQ-035 SHALL cover: write 0xA5 at 7 and 2, search 0xA5 -> search_index_o=2; with CAM_MULTI_HIT_EN, multi_hit_o=1.
REQ-036 SHALL cover: invalidate 3 then search 0xDEADBEEF -> search_valid_o=0, search_index_o=0, count_o decremented by 1.
REQ-037 SHALL cover: same-cycle write 0x55 at 4 and read 4 of prior 0x11 -> read_value_o=0x11; next read returns 0x55.
REQ-038 SHALL cover: same-cycle write and invalidate at index 5 (previously invalid) -> entry valid, count_o +1.
REQ-039 SHALL cover: fill all DEPTH entries -> count_o=DEPTH; assert rst_i low mid-search -> all outputs 0 at once, count_o=0.
